// File: rtl/prbs_pkg.sv
// ============================================================================
// prbs_pkg : shared constants and helpers for the PRBS checker
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package prbs_pkg;

    localparam int              PRBS_W     = 6;
    localparam int              PRBS_PCW   = $clog2(PRBS_W + 1);
    localparam int              PRBS_TAP_A = 5;
    localparam int              PRBS_TAP_B = 1;
    localparam logic [PRBS_W-1:0] PRBS_SEED = 6'h1F;

    typedef logic [1:0] prbs_state_t;

    localparam prbs_state_t ST_HUNT    = 2'd0;
    localparam prbs_state_t ST_LOCKING = 2'd1;
    localparam prbs_state_t ST_LOCKED  = 2'd2;

    function automatic logic [PRBS_W-1:0] lfsr_shift1(input logic [PRBS_W-1:0] x);
        return {x[PRBS_TAP_A] ^ x[PRBS_TAP_B], x[PRBS_W-1:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/prbs_step.sv
// ============================================================================
// prbs_step : combinational advance of the reference LFSR by BITS shifts
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module prbs_step
    import prbs_pkg::*;
#(
    parameter int BITS = 6
) (
    input  logic [PRBS_W-1:0] x_i,
    output logic [PRBS_W-1:0] y_o
);

    logic [PRBS_W-1:0] w_chain [BITS+1];

    assign w_chain[0] = x_i;

    for (genvar i = 0; i < BITS; i++) begin : g_shift
        assign w_chain[i+1] = lfsr_shift1(w_chain[i]);
    end

    assign y_o = w_chain[BITS];

endmodule

`default_nettype wire

// File: rtl/prbs_checker.sv
// ============================================================================
// prbs_checker : PRBS lock/track checker with saturating error statistics
// Optional     : define PRBS_CHK_BITSTATS_EN to enable per-bit error counting
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module prbs_checker
    import prbs_pkg::*;
#(
    parameter int BITS     = 6,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PRBS_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              err_clr,
    output logic              locked,
    output logic              err_pulse,
    output logic              lost,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ERR_W-1:0]  bit_err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] c_LOCK_CNT = MW'(LOCK_CNT);
    localparam logic [LW-1:0] c_LOSS_CNT = LW'(LOSS_CNT);

    prbs_state_t       state_q, state_d;
    logic [PRBS_W-1:0] ref_q, ref_d;
    logic [MW-1:0]     match_q, match_d;
    logic [LW-1:0]     miss_q, miss_d;
    logic              locked_q, locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic              lost_q, lost_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_hit;

    logic [PRBS_W-1:0] w_expect;
    logic              w_mismatch;
    logic [MW-1:0]     w_match_inc;
    logic [LW-1:0]     w_miss_inc;

    prbs_step #(
        .BITS (BITS)
    ) u_step (
        .x_i (ref_q),
        .y_o (w_expect)
    );

    assign w_mismatch  = (data_in != w_expect);
    assign w_match_inc = match_q + MW'(1);
    assign w_miss_inc  = miss_q + LW'(1);

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        match_d     = match_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        lost_d      = 1'b0;
        err_hit     = 1'b0;
        if (valid_in) begin
            case (state_q)
                ST_HUNT: begin
                    // All-zero is the LFSR lock-up value and can never seed a sequence
                    if (data_in != '0) begin
                        ref_d   = data_in;
                        match_d = '0;
                        state_d = ST_LOCKING;
                    end
                end
                ST_LOCKING: begin
                    if (!w_mismatch) begin
                        ref_d   = data_in;
                        match_d = w_match_inc;
                        if (w_match_inc == c_LOCK_CNT) begin
                            state_d  = ST_LOCKED;
                            miss_d   = '0;
                            locked_d = 1'b1;
                        end
                    end else if (data_in != '0) begin
                        ref_d   = data_in;
                        match_d = '0;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    // Free-run the reference so corrupted samples never pollute it
                    ref_d = w_expect;
                    if (w_mismatch) begin
                        err_pulse_d = 1'b1;
                        err_hit     = 1'b1;
                        if (w_miss_inc == c_LOSS_CNT) begin
                            state_d  = ST_HUNT;
                            miss_d   = '0;
                            locked_d = 1'b0;
                            lost_d   = 1'b1;
                        end else begin
                            miss_d = w_miss_inc;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d  = ST_HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (err_hit && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            ref_q       <= PRBS_SEED;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            lost_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            lost_q      <= lost_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign lost      = lost_q;
    assign err_cnt   = err_cnt_q;

`ifdef PRBS_CHK_BITSTATS_EN
    function automatic logic [PRBS_PCW-1:0] popcount(input logic [PRBS_W-1:0] x);
        logic [PRBS_PCW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < PRBS_W; i++) begin
            cnt = cnt + PRBS_PCW'(x[i]);
        end
        return cnt;
    endfunction

    logic [ERR_W-1:0] bit_err_q, bit_err_d;
    logic [ERR_W:0]   w_bit_sum;

    assign w_bit_sum = {1'b0, bit_err_q} + (ERR_W+1)'(popcount(data_in ^ w_expect));

    always_comb begin
        bit_err_d = bit_err_q;
        if (err_clr) begin
            bit_err_d = '0;
        end else if (err_hit) begin
            bit_err_d = w_bit_sum[ERR_W] ? '1 : w_bit_sum[ERR_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_err_q <= '0;
        end else begin
            bit_err_q <= bit_err_d;
        end
    end

    assign bit_err_cnt = bit_err_q;
`else
    assign bit_err_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
// ============================================================================
// tb_prbs_checker : directed self-checking bench for prbs_checker (ERR_W=4)
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module tb_prbs_checker;

`ifdef PRBS_CHK_BITSTATS_EN
    localparam bit BS = 1'b1;
`else
    localparam bit BS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] data_in;
    logic       valid_in;
    logic       err_clr;
    logic       locked;
    logic       err_pulse;
    logic       lost;
    logic [3:0] err_cnt;
    logic [3:0] bit_err_cnt;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    // Hand-derived sequence: each entry is step() of the previous one, period 7
    logic [5:0] seq [7] = '{6'h1F, 6'h25, 6'h11, 6'h38, 6'h2B, 6'h0C, 6'h02};

    prbs_checker #(
        .BITS     (6),
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .ERR_W    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .err_clr     (err_clr),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .lost        (lost),
        .err_cnt     (err_cnt),
        .bit_err_cnt (bit_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [5:0] d, input logic clr);
        @(negedge clk);
        data_in  = d;
        valid_in = 1'b1;
        err_clr  = clr;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic idle(input logic clr);
        @(negedge clk);
        valid_in = 1'b0;
        err_clr  = clr;
        @(posedge clk);
        #1;
        err_clr  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; valid_in = 1'b0; err_clr = 1'b0; data_in = 6'h00;
        #12;
        checks++; if (locked !== 1'b0)      begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
        checks++; if (err_pulse !== 1'b0)   begin errors++; $display("FAIL reset_err_pulse got %b want 0", err_pulse); end
        checks++; if (lost !== 1'b0)        begin errors++; $display("FAIL reset_lost got %b want 0", lost); end
        checks++; if (err_cnt !== 4'h0)     begin errors++; $display("FAIL reset_err_cnt got %h want 0", err_cnt); end
        checks++; if (bit_err_cnt !== 4'h0) begin errors++; $display("FAIL reset_bit_err_cnt got %h want 0", bit_err_cnt); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_acquire;
        for (int i = 0; i < 4; i++) begin
            send(seq[i], 1'b0);
            checks++; if (locked !== 1'b0) begin errors++; $display("FAIL acquire_early_lock[%0d] got %b want 0", i, locked); end
        end
        send(seq[4], 1'b0);
        checks++; if (locked !== 1'b1)  begin errors++; $display("FAIL acquire_lock got %b want 1", locked); end
        checks++; if (err_cnt !== 4'h0) begin errors++; $display("FAIL acquire_err_cnt got %h want 0", err_cnt); end
        k = 5;
    endtask

    task automatic test_single_error;
        send(6'h00, 1'b0);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_err_pulse got %b want 1", err_pulse); end
        checks++; if (err_cnt !== 4'h1)   begin errors++; $display("FAIL single_err_cnt got %h want 1", err_cnt); end
        checks++; if (locked !== 1'b1)    begin errors++; $display("FAIL single_locked got %b want 1", locked); end
        checks++; if (bit_err_cnt !== (BS ? 4'h2 : 4'h0)) begin errors++; $display("FAIL single_bits got %h want %h", bit_err_cnt, BS ? 4'h2 : 4'h0); end
        send(seq[6], 1'b0);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_recover_pulse got %b want 0", err_pulse); end
        checks++; if (err_cnt !== 4'h1)   begin errors++; $display("FAIL single_recover_cnt got %h want 1", err_cnt); end
        checks++; if (locked !== 1'b1)    begin errors++; $display("FAIL single_recover_locked got %b want 1", locked); end
        k = 0;
    endtask

    task automatic test_loss_with_gaps;
        idle(1'b1);
        checks++; if (err_cnt !== 4'h0) begin errors++; $display("FAIL loss_clr_cnt got %h want 0", err_cnt); end
        checks++; if (locked !== 1'b1)  begin errors++; $display("FAIL loss_clr_locked got %b want 1", locked); end
        for (int i = 0; i < 3; i++) begin
            send(6'h00, 1'b0);
            checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL loss_pulse[%0d] got %b want 1", i, err_pulse); end
            checks++; if (err_cnt !== 4'(i + 1)) begin errors++; $display("FAIL loss_cnt[%0d] got %h want %h", i, err_cnt, 4'(i + 1)); end
            if (i < 2) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_early_unlock[%0d] got %b want 1", i, locked); end
                checks++; if (lost !== 1'b0)   begin errors++; $display("FAIL loss_early_lost[%0d] got %b want 0", i, lost); end
            end else begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_unlock got %b want 0", locked); end
                checks++; if (lost !== 1'b1)   begin errors++; $display("FAIL loss_lost got %b want 1", lost); end
                checks++; if (bit_err_cnt !== (BS ? 4'hA : 4'h0)) begin errors++; $display("FAIL loss_bits got %h want %h", bit_err_cnt, BS ? 4'hA : 4'h0); end
            end
            idle(1'b0);
            idle(1'b0);
            checks++; if (err_pulse !== 1'b0)    begin errors++; $display("FAIL loss_gap_pulse[%0d] got %b want 0", i, err_pulse); end
            checks++; if (lost !== 1'b0)         begin errors++; $display("FAIL loss_gap_lost[%0d] got %b want 0", i, lost); end
            checks++; if (err_cnt !== 4'(i + 1)) begin errors++; $display("FAIL loss_gap_cnt[%0d] got %h want %h", i, err_cnt, 4'(i + 1)); end
        end
    endtask

    task automatic test_hunt_zero;
        send(6'h00, 1'b0);
        checks++; if (locked !== 1'b0)    begin errors++; $display("FAIL hunt_zero_locked got %b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL hunt_zero_pulse got %b want 0", err_pulse); end
        checks++; if (err_cnt !== 4'h3)   begin errors++; $display("FAIL hunt_retained_cnt got %h want 3", err_cnt); end
        for (int i = 1; i <= 4; i++) begin
            send(seq[i], 1'b0);
            checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early[%0d] got %b want 0", i, locked); end
        end
        send(seq[5], 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", locked); end
        k = 6;
    endtask

    task automatic test_saturation;
        idle(1'b1);
        for (int i = 0; i < 17; i++) begin
            send(seq[k] ^ 6'h01, 1'b0);
            k = (k + 1) % 7;
            checks++;
            if (err_cnt !== ((i + 1 > 15) ? 4'hF : 4'(i + 1))) begin
                errors++;
                $display("FAIL sat_cnt[%0d] got %h want %h", i, err_cnt, (i + 1 > 15) ? 4'hF : 4'(i + 1));
            end
            send(seq[k], 1'b0);
            k = (k + 1) % 7;
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked got %b want 1", locked); end
        checks++; if (bit_err_cnt !== (BS ? 4'hF : 4'h0)) begin errors++; $display("FAIL sat_bits got %h want %h", bit_err_cnt, BS ? 4'hF : 4'h0); end
    endtask

    task automatic test_clear_wins;
        send(seq[k] ^ 6'h01, 1'b1);
        k = (k + 1) % 7;
        checks++; if (err_cnt !== 4'h0)     begin errors++; $display("FAIL clr_cnt got %h want 0", err_cnt); end
        checks++; if (bit_err_cnt !== 4'h0) begin errors++; $display("FAIL clr_bits got %h want 0", bit_err_cnt); end
        checks++; if (err_pulse !== 1'b1)   begin errors++; $display("FAIL clr_pulse got %b want 1", err_pulse); end
        checks++; if (locked !== 1'b1)      begin errors++; $display("FAIL clr_locked got %b want 1", locked); end
        send(seq[k], 1'b0);
        k = (k + 1) % 7;
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL clr_next_pulse got %b want 0", err_pulse); end
        checks++; if (err_cnt !== 4'h0)   begin errors++; $display("FAIL clr_next_cnt got %h want 0", err_cnt); end
    endtask

    task automatic test_bitstats;
        while (k != 1) begin send(seq[k], 1'b0); k = (k + 1) % 7; end
        send(6'h24, 1'b0);
        k = 2;
        checks++; if (err_cnt !== 4'h1) begin errors++; $display("FAIL bits_a_cnt got %h want 1", err_cnt); end
        checks++; if (bit_err_cnt !== (BS ? 4'h1 : 4'h0)) begin errors++; $display("FAIL bits_a got %h want %h", bit_err_cnt, BS ? 4'h1 : 4'h0); end
        while (k != 1) begin send(seq[k], 1'b0); k = (k + 1) % 7; end
        send(6'h1A, 1'b0);
        k = 2;
        checks++; if (err_cnt !== 4'h2) begin errors++; $display("FAIL bits_b_cnt got %h want 2", err_cnt); end
        checks++; if (bit_err_cnt !== (BS ? 4'h7 : 4'h0)) begin errors++; $display("FAIL bits_b got %h want %h", bit_err_cnt, BS ? 4'h7 : 4'h0); end
        send(seq[k], 1'b0);
        k = (k + 1) % 7;
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL bits_locked got %b want 1", locked); end
    endtask

    task automatic test_reset_midlock;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (locked !== 1'b0)  begin errors++; $display("FAIL midrst_locked got %b want 0", locked); end
        checks++; if (lost !== 1'b0)    begin errors++; $display("FAIL midrst_lost got %b want 0", lost); end
        checks++; if (err_cnt !== 4'h0) begin errors++; $display("FAIL midrst_cnt got %h want 0", err_cnt); end
        @(posedge clk);
        #1;
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL midrst_lost_edge got %b want 0", lost); end
        @(negedge clk);
        reset = 1'b0;
        send(seq[k], 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midrst_hunt got %b want 0", locked); end
        checks++; if (lost !== 1'b0)   begin errors++; $display("FAIL midrst_after_lost got %b want 0", lost); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_acquire();
        test_single_error();
        test_loss_with_gaps();
        test_hunt_zero();
        test_saturation();
        test_clear_wins();
        test_bitstats();
        test_reset_midlock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
